timer_array: RTL and testbench

Parametrised multi-channel timer/counter peripheral that replaces the single-channel `timecounter` on the CPU device bus behind the bridge. It provides `CH` independent channels, each with a prescaler, three counting modes and a maskable interrupt. The per-channel interrupt lines feed the CPU hardware-interrupt vector (`HardInt_in`), and their OR is provided for single-line use.

---
 rtl/timer_array.sv | 169 ++++++++++++++++
 tb/tb_timer_array.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_array.sv
// Multi-channel timer/counter on the CPU device bus: per-channel prescaler,
// one-shot / auto-reload / free-run counting and a maskable pending interrupt.
module timer_array #(
  parameter int CH    = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(CH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [CH-1:0] irq,
  output logic          irq_any
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [CH-1:0]    en, im, pend;
  logic [CH-1:0]    en_nx, im_nx, pend_nx;
  logic [1:0]       mode [CH];
  logic [1:0]       mode_nx [CH];
  logic [7:0]       pre [CH];
  logic [7:0]       pre_nx [CH];
  logic [7:0]       pcnt [CH];
  logic [7:0]       pcnt_nx [CH];
  logic [WIDTH-1:0] preset [CH];
  logic [WIDTH-1:0] preset_nx [CH];
  logic [WIDTH-1:0] count [CH];
  logic [WIDTH-1:0] count_nx [CH];

  logic [7:0] sel;
  logic [1:0] reg_sel;

  assign sel     = 8'(addr >> 2);
  assign reg_sel = addr[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] nw,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? nw[8*b +: 8] : old[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    logic        tick, ev, wr_ctrl, wr_pre, w1c;
    logic [31:0] merged;
    tick    = 1'b0;
    ev      = 1'b0;
    wr_ctrl = 1'b0;
    wr_pre  = 1'b0;
    w1c     = 1'b0;
    merged  = '0;
    for (int i = 0; i < CH; i++) begin
      en_nx[i]     = en[i];
      im_nx[i]     = im[i];
      mode_nx[i]   = mode[i];
      pre_nx[i]    = pre[i];
      pcnt_nx[i]   = pcnt[i];
      preset_nx[i] = preset[i];
      count_nx[i]  = count[i];
      tick    = en[i] && (pcnt[i] == pre[i]);
      ev      = 1'b0;
      wr_ctrl = we && (sel == 8'(i)) && (reg_sel == REG_CTRL);
      wr_pre  = we && (sel == 8'(i)) && (reg_sel == REG_PRESET);
      w1c     = we && (sel == 8'(i)) && (reg_sel == REG_STATUS) && be[0] && din[0];
      merged  = byte_merge(32'(preset[i]), din, be);

      // Software writes pre-empt the tick of the same cycle and restart the prescaler.
      if (wr_ctrl) begin
        if (be[0]) begin
          en_nx[i]   = din[0];
          mode_nx[i] = din[2:1];
          im_nx[i]   = din[3];
        end
        if (be[1]) pre_nx[i] = din[15:8];
        pcnt_nx[i] = '0;
      end else if (wr_pre) begin
        preset_nx[i] = merged[WIDTH-1:0];
        count_nx[i]  = merged[WIDTH-1:0];
        pcnt_nx[i]   = '0;
      end else begin
        pcnt_nx[i] = (!en[i] || tick) ? 8'd0 : pcnt[i] + 8'd1;
        if (tick) begin
          case (mode[i])
            2'b10: begin
              count_nx[i] = count[i] + WIDTH'(1);
              ev          = &count[i];
            end
            2'b01: begin
              if (count[i] > WIDTH'(1)) begin
                count_nx[i] = count[i] - WIDTH'(1);
              end else if (count[i] == WIDTH'(1)) begin
                count_nx[i] = preset[i];
                ev          = 1'b1;
              end
            end
            default: begin
              if (count[i] > WIDTH'(1)) begin
                count_nx[i] = count[i] - WIDTH'(1);
              end else if (count[i] == WIDTH'(1)) begin
                count_nx[i] = '0;
                ev          = 1'b1;
                en_nx[i]    = 1'b0;
              end else begin
                en_nx[i] = 1'b0;
              end
            end
          endcase
        end
      end

      // A hardware event outranks a simultaneous write-1-to-clear.
      pend_nx[i] = ev ? 1'b1 : (w1c ? 1'b0 : pend[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= '0;
      im   <= '0;
      pend <= '0;
      for (int i = 0; i < CH; i++) begin
        mode[i]   <= '0;
        pre[i]    <= '0;
        pcnt[i]   <= '0;
        preset[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      en   <= en_nx;
      im   <= im_nx;
      pend <= pend_nx;
      for (int i = 0; i < CH; i++) begin
        mode[i]   <= mode_nx[i];
        pre[i]    <= pre_nx[i];
        pcnt[i]   <= pcnt_nx[i];
        preset[i] <= preset_nx[i];
        count[i]  <= count_nx[i];
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel == 8'(i)) begin
        case (reg_sel)
          REG_CTRL:   dout = {16'h0, pre[i], 4'h0, im[i], mode[i], en[i]};
          REG_PRESET: dout = 32'(preset[i]);
          REG_COUNT:  dout = 32'(count[i]);
          default:    dout = {31'h0, pend[i]};
        endcase
      end
    end
  end

  assign irq     = pend & im;
  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_array.sv
// Randomised and directed bench for timer_array with a queue-based scoreboard
// fed by a behavioural channel model.
module tb_timer_array;
  localparam int CH    = 3;
  localparam int WIDTH = 16;
  localparam int AW    = $clog2(CH) + 2;
  localparam longint MAXV = (64'd1 << WIDTH) - 1;

  logic          clk = 1'b0;
  logic          rst, we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic [CH-1:0] irq;
  logic          irq_any;

  always #5 clk = ~clk;

  timer_array #(.CH(CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .be(be), .din(din),
    .dout(dout), .irq(irq), .irq_any(irq_any)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   dout;
    logic [CH-1:0] irq;
    logic          irq_any;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit         m_en[CH], m_im[CH], m_pend[CH];
  bit [1:0]   m_mode[CH];
  bit [7:0]   m_pre[CH], m_pcnt[CH];
  longint     m_preset[CH], m_count[CH];

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      m_en[c] = 0; m_im[c] = 0; m_pend[c] = 0; m_mode[c] = 0;
      m_pre[c] = 0; m_pcnt[c] = 0; m_preset[c] = 0; m_count[c] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    int c, r;
    c = a / 4;
    r = a % 4;
    if (c >= CH) return 32'h0;
    case (r)
      0: return {16'h0, m_pre[c], 4'h0, m_im[c], m_mode[c], m_en[c]};
      1: return 32'(m_preset[c]);
      2: return 32'(m_count[c]);
      default: return {31'h0, m_pend[c]};
    endcase
  endfunction

  function automatic logic [CH-1:0] m_irq();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_pend[c] & m_im[c];
    return v;
  endfunction

  task automatic m_step(input bit r, input bit w, input int a, input bit [3:0] b,
                        input bit [31:0] d);
    int  c_sel, r_sel;
    bit  tick, ev;
    longint np;
    if (r) begin
      m_reset();
      return;
    end
    c_sel = a / 4;
    r_sel = a % 4;
    for (int c = 0; c < CH; c++) begin
      tick = m_en[c] && (m_pcnt[c] == m_pre[c]);
      ev   = 0;
      if (w && c == c_sel && r_sel == 0) begin
        if (b[0]) begin
          m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3];
        end
        if (b[1]) m_pre[c] = d[15:8];
        m_pcnt[c] = 0;
      end else if (w && c == c_sel && r_sel == 1) begin
        np = m_preset[c];
        for (int k = 0; k < 4; k++)
          if (b[k]) np = (np & ~(64'hFF << (8 * k))) | (longint'(d[8*k +: 8]) << (8 * k));
        np = np & MAXV;
        m_preset[c] = np;
        m_count[c]  = np;
        m_pcnt[c]   = 0;
      end else begin
        m_pcnt[c] = (!m_en[c] || tick) ? 8'd0 : m_pcnt[c] + 8'd1;
        if (tick) begin
          if (m_mode[c] == 2) begin
            if (m_count[c] == MAXV) begin
              m_count[c] = 0; ev = 1;
            end else m_count[c] = m_count[c] + 1;
          end else if (m_mode[c] == 1) begin
            if (m_count[c] == 1) begin
              m_count[c] = m_preset[c]; ev = 1;
            end else if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
          end else begin
            if (m_count[c] == 1) begin
              m_count[c] = 0; ev = 1; m_en[c] = 0;
            end else if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
            else m_en[c] = 0;
          end
        end
      end
      if (ev) m_pend[c] = 1;
      else if (w && c == c_sel && r_sel == 3 && b[0] && d[0]) m_pend[c] = 0;
    end
  endtask

  // Monitor: compares the DUT's outputs against the expectation queued for this cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (dout !== e.dout) begin
        errors++;
        $display("FAIL dout[addr=%0d] at %0t: got %h, expected %h", e.a, $time, dout, e.dout);
      end
      checks++;
      if (irq !== e.irq) begin
        errors++;
        $display("FAIL irq at %0t: got %b, expected %b", $time, irq, e.irq);
      end
      checks++;
      if (irq_any !== e.irq_any) begin
        errors++;
        $display("FAIL irq_any at %0t: got %b, expected %b", $time, irq_any, e.irq_any);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input int a, input bit [3:0] b,
                       input bit [31:0] d, output logic [31:0] got);
    exp_t e;
    rst = r; we = w; addr = AW'(a); be = b; din = d;
    e.a = AW'(a);
    e.dout = m_read(a);
    e.irq = m_irq();
    e.irq_any = |e.irq;
    q.push_back(e);
    #1 got = dout;
    @(posedge clk);
    m_step(r, w, a, b, d);
    #1;
  endtask

  logic [31:0] g;

  task automatic rd(input int a);
    cycle(0, 0, a, 4'h0, 32'h0, g);
  endtask

  task automatic wr(input int a, input bit [31:0] d, input bit [3:0] b);
    cycle(0, 1, a, b, d, g);
  endtask

  initial begin
    int n;
    rst = 1; we = 0; addr = '0; be = '0; din = '0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;

    // Reset state and the unused channel slot
    for (int a = 0; a < 16; a++) rd(a);
    chk("reset_irq", irq, 0);
    wr(12, 32'hFFFF_FFFF, 4'hF);
    wr(13, 32'hFFFF_FFFF, 4'hF);
    for (int a = 0; a < 16; a++) rd(a);

    // Channel 0 one-shot, PRE=0, PRESET=5
    wr(0, 32'h0009, 4'hF);
    wr(1, 32'd5, 4'hF);
    n = 0;
    while (!irq[0] && n < 40) begin rd(2); n++; end
    chk("oneshot_latency", n, 5);
    repeat (50) rd($urandom_range(0, 3));
    cycle(0, 0, 0, 4'h0, 32'h0, g);
    chk("oneshot_en_cleared", g, 32'h0008);
    wr(3, 32'h1, 4'h1);
    chk("oneshot_w1c", irq[0], 0);

    // Channel 1 auto-reload, PRE=3, PRESET=4
    wr(4, 32'h030B, 4'hF);
    wr(5, 32'd4, 4'hF);
    n = 0;
    while (!irq[1] && n < 60) begin rd(6); n++; end
    chk("reload_first", n, 16);
    wr(7, 32'h1, 4'h1);
    chk("reload_w1c", irq[1], 0);
    n = 0;
    while (!irq[1] && n < 60) begin rd(6); n++; end
    chk("reload_period", n + 1, 16);
    wr(7, 32'h1, 4'h1);
    chk("reload_w1c2", irq[1], 0);
    repeat (14) rd(6);
    wr(7, 32'h1, 4'h1);
    chk("reload_set_wins", irq[1], 1);
    wr(4, 32'h0, 4'hF);
    wr(7, 32'h1, 4'h1);

    // Channel 2 free-run wrap with interrupt masked
    wr(8, 32'h0005, 4'hF);
    wr(9, 32'hFFFE, 4'hF);
    rd(10); rd(10);
    cycle(0, 0, 11, 4'h0, 32'h0, g);
    chk("freerun_pend", g, 1);
    chk("freerun_masked_irq", irq[2], 0);
    chk("freerun_masked_any", irq_any, 0);
    wr(8, 32'h000D, 4'h1);
    chk("freerun_unmask_irq", irq[2], 1);
    chk("freerun_unmask_any", irq_any, 1);
    wr(8, 32'h0, 4'hF);
    wr(11, 32'h1, 4'h1);

    // PRESET byte-lane write and width truncation
    wr(9, 32'h1122_3344, 4'hF);
    cycle(0, 0, 9, 4'h0, 32'h0, g);
    chk("preset_truncated", g, 32'h3344);
    wr(9, 32'hAABB_CCDD, 4'b0001);
    cycle(0, 0, 9, 4'h0, 32'h0, g);
    chk("preset_byte0", g, 32'h33DD);
    cycle(0, 0, 10, 4'h0, 32'h0, g);
    chk("count_reload_byte0", g, 32'h33DD);

    // Reset while channels 0 and 1 are counting
    wr(0, 32'h0209, 4'hF);
    wr(1, 32'd100, 4'hF);
    wr(4, 32'h010B, 4'hF);
    wr(5, 32'd50, 4'hF);
    repeat (10) rd($urandom_range(0, 7));
    cycle(1, 0, 2, 4'h0, 32'h0, g);
    for (int a = 0; a < 16; a++) begin
      rd(a);
      chk("post_reset_irq", irq, 0);
    end

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      int a;
      bit [31:0] d;
      a = $urandom_range(0, 15);
      d = $urandom;
      if (a % 4 == 0) d[15:8] = 8'($urandom_range(0, 3));
      if (a % 4 == 1) d = ($urandom_range(0, 3) == 0) ? 32'hFFF0 + $urandom_range(0, 15)
                                                      : $urandom_range(0, 20);
      if ($urandom_range(0, 299) == 0)
        cycle(1, 0, a, 4'h0, 32'h0, g);
      else if ($urandom_range(0, 9) < 3)
        cycle(0, 1, a, 4'($urandom_range(0, 15)), d, g);
      else
        cycle(0, 0, a, 4'h0, 32'h0, g);
    end

    rst = 0; we = 0;
    n = 0;
    while (q.size() > 0 && n < 5) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
